// File: rtl/gray_counter_p.sv
// gray_counter_p: up/down binary counter with a registered Gray-code mirror.
//
// Parameters:
//   WIDTH     counter width in bits (2..32)
//   SAT_MODE  0 = wrap at terminal count, 1 = saturate at terminal count
//   RESET_VAL binary count loaded by reset (must be < 2**WIDTH)
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   en        count enable, one step per cycle while high
//   up_dn     direction, 1 = increment, 0 = decrement
//   clr       synchronous clear to zero (highest priority)
//   load      synchronous load strobe           (GRAY_CNT_LOAD_EN only)
//   load_gray Gray-coded load value             (GRAY_CNT_LOAD_EN only)
//   gray_out  registered Gray code of the count
//   bin_out   registered binary count
//   tc        terminal count for the current direction (combinational)
//   wrap      registered one-cycle pulse after a wrap-around step
//
// Build option: define GRAY_CNT_LOAD_EN to add the load / load_gray ports
// and the Gray-to-binary load path. Without it the priority is clr > en > hold.

module gray_counter_p #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SAT_MODE  = 0,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
`ifdef GRAY_CNT_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
`endif
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;

    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] gray_nxt;
    logic             wrap_nxt;
    logic             at_tc;
    logic             hold_sat;

`ifdef GRAY_CNT_LOAD_EN
    logic [WIDTH-1:0] load_bin;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        load_bin = '0;
        load_bin[WIDTH-1] = load_gray[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            load_bin[i] = load_bin[i+1] ^ load_gray[i];
        end
    end
`endif

    // Terminal count depends on the live direction input so a direction
    // change is honoured on the same edge.
    always_comb begin
        at_tc    = (up_dn && (cnt == CNT_MAX)) || (!up_dn && (cnt == CNT_ZERO));
        hold_sat = at_tc && (SAT_MODE != 0);
    end

    // Next-state selection: clr > load > en > hold.
    always_comb begin
        cnt_nxt  = cnt;
        gray_nxt = gray_q;
        wrap_nxt = 1'b0;
        if (clr) begin
            cnt_nxt  = CNT_ZERO;
            gray_nxt = CNT_ZERO;
        end
`ifdef GRAY_CNT_LOAD_EN
        else if (load) begin
            cnt_nxt  = load_bin;
            gray_nxt = load_gray;
        end
`endif
        else if (en && !hold_sat) begin
            // Modulo arithmetic gives max->0 and 0->max for free.
            cnt_nxt  = up_dn ? (cnt + CNT_ONE) : (cnt - CNT_ONE);
            gray_nxt = cnt_nxt ^ (cnt_nxt >> 1);
            wrap_nxt = at_tc;
        end
    end

    // State registers; reset discards any in-flight step and pending pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= RST_BIN;
            gray_q <= RST_GRAY;
            wrap_q <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            gray_q <= gray_nxt;
            wrap_q <= wrap_nxt;
        end
    end

    assign bin_out  = cnt;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;
    assign tc       = at_tc;

endmodule

// File: tb/tb_gray_counter_p.sv
// tb_gray_counter_p: directed-vector bench for gray_counter_p.
// Three instances: wrap mode (u_dut), saturating mode (u_sat) and a
// RESET_VAL=5 instance (u_rv5). Load checks build with GRAY_CNT_LOAD_EN.

module tb_gray_counter_p;

    logic       clk;
    logic       rst;
    logic       en, up_dn, clr;
    logic       en_s, up_s;
    logic [7:0] gray_out, bin_out, gray_s, bin_s, gray_r, bin_r;
    logic       tc, wrap, tc_s, wrap_s, tc_r, wrap_r;
`ifdef GRAY_CNT_LOAD_EN
    logic       ld;
    logic [7:0] ld_gray;
`endif

    int n_vec;
    int n_err;

    gray_counter_p #(.WIDTH(8), .SAT_MODE(0), .RESET_VAL(0)) u_dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr),
`ifdef GRAY_CNT_LOAD_EN
        .load(ld), .load_gray(ld_gray),
`endif
        .gray_out(gray_out), .bin_out(bin_out), .tc(tc), .wrap(wrap)
    );

    gray_counter_p #(.WIDTH(8), .SAT_MODE(1), .RESET_VAL(0)) u_sat (
        .clk(clk), .rst(rst), .en(en_s), .up_dn(up_s), .clr(1'b0),
`ifdef GRAY_CNT_LOAD_EN
        .load(1'b0), .load_gray(8'h00),
`endif
        .gray_out(gray_s), .bin_out(bin_s), .tc(tc_s), .wrap(wrap_s)
    );

    gray_counter_p #(.WIDTH(8), .SAT_MODE(0), .RESET_VAL(5)) u_rv5 (
        .clk(clk), .rst(rst), .en(1'b0), .up_dn(1'b1), .clr(1'b0),
`ifdef GRAY_CNT_LOAD_EN
        .load(1'b0), .load_gray(8'h00),
`endif
        .gray_out(gray_r), .bin_out(bin_r), .tc(tc_r), .wrap(wrap_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Short reset pulse strictly between clock edges; checks taken while held.
    task automatic mid_rst(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, "_bin"},  32'(bin_out),  32'h00);
        check({tag, "_gray"}, 32'(gray_out), 32'h00);
        check({tag, "_wrap"}, 32'(wrap),     32'h0);
        #1 rst = 1'b0;
    endtask

    logic [7:0] eb, pg, eg;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0;
        en_s = 1'b0; up_s = 1'b1;
`ifdef GRAY_CNT_LOAD_EN
        ld = 1'b0; ld_gray = 8'h00;
`endif
        #1 rst = 1'b1;
        #2;
        check("rst_bin",      32'(bin_out),  32'h00);
        check("rst_gray",     32'(gray_out), 32'h00);
        check("rst_wrap",     32'(wrap),     32'h0);
        check("rst5_bin",     32'(bin_r),    32'h05);
        check("rst5_gray",    32'(gray_r),   32'h07);
        @(negedge clk) rst = 1'b0;

        // Count three, then reset between edges.
        en = 1'b1; up_dn = 1'b1;
        repeat (3) step();
        check("pre_rst_bin", 32'(bin_out), 32'h03);
        mid_rst("midrst");
        check("midrst5_bin",  32'(bin_r),  32'h05);
        check("midrst5_gray", 32'(gray_r), 32'h07);

        // Full up lap from 0: one-bit Gray steps, tc at 0xFF, wrap pulse.
        pg = 8'h00;
        for (int i = 0; i < 256; i++) begin
            eb = 8'(i + 1);
            check("lap_tc", 32'(tc), (i == 255) ? 32'h1 : 32'h0);
            step();
            eg = eb ^ (eb >> 1);
            check("lap_bin",  32'(bin_out), 32'(eb));
            check("lap_gray", 32'(gray_out), 32'(eg));
            check("lap_1bit", 32'($countones(gray_out ^ pg)), 32'd1);
            check("lap_wrap", 32'(wrap), (eb == 8'h00) ? 32'h1 : 32'h0);
            pg = gray_out;
        end
        step();
        check("postwrap_bin",  32'(bin_out), 32'h01);
        check("postwrap_wrap", 32'(wrap),    32'h0);

        // Clear beats enable.
        clr = 1'b1;
        step();
        check("clr_bin",  32'(bin_out),  32'h00);
        check("clr_gray", 32'(gray_out), 32'h00);
        clr = 1'b0;

        // Up to 0x10, reverse with no dead cycle, then hold.
        repeat (16) step();
        check("up16_bin",  32'(bin_out),  32'h10);
        check("up16_gray", 32'(gray_out), 32'h18);
        up_dn = 1'b0;
        step();
        check("rev_bin",  32'(bin_out),  32'h0F);
        check("rev_gray", 32'(gray_out), 32'h08);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_bin",  32'(bin_out),  32'h0F);
            check("hold_gray", 32'(gray_out), 32'h08);
            check("hold_wrap", 32'(wrap),     32'h0);
        end

        // Down wrap from 0, then reset kills the pending wrap pulse.
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("dn_tc0", 32'(tc), 32'h1);
        up_dn = 1'b1;
        #1;
        check("up_tc0", 32'(tc), 32'h0);
        up_dn = 1'b0; en = 1'b1;
        step();
        check("dnwrap_bin",  32'(bin_out),  32'hFF);
        check("dnwrap_gray", 32'(gray_out), 32'h80);
        check("dnwrap_wrap", 32'(wrap),     32'h1);
        mid_rst("wraprst");

        // Count up to 0x40, reset mid-cycle, resume from reset value.
        up_dn = 1'b1;
        repeat (64) step();
        check("up40_bin", 32'(bin_out), 32'h40);
        mid_rst("rst40");
        step();
        check("resume_bin",  32'(bin_out), 32'h01);
        check("resume_wrap", 32'(wrap),    32'h0);
        en = 1'b0;

        // Saturating instance: up to 2, then down into the floor.
        en_s = 1'b1; up_s = 1'b1;
        repeat (2) step();
        check("sat_up_bin", 32'(bin_s), 32'h02);
        up_s = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("sat_bin",  32'(bin_s),  (i == 0) ? 32'h01 : 32'h00);
            check("sat_gray", 32'(gray_s), (i == 0) ? 32'h01 : 32'h00);
            check("sat_wrap", 32'(wrap_s), 32'h0);
            check("sat_tc",   32'(tc_s),   (i == 0) ? 32'h0 : 32'h1);
        end
        en_s = 1'b0;

`ifdef GRAY_CNT_LOAD_EN
        // Load takes Gray input; clr overrides load; load beats enable.
        en = 1'b1; up_dn = 1'b1;
        ld = 1'b1; ld_gray = 8'hC0;
        step();
        check("ld_bin",  32'(bin_out),  32'h80);
        check("ld_gray", 32'(gray_out), 32'hC0);
        check("ld_wrap", 32'(wrap),     32'h0);
        clr = 1'b1;
        step();
        check("ldclr_bin",  32'(bin_out),  32'h00);
        check("ldclr_gray", 32'(gray_out), 32'h00);
        clr = 1'b0; ld_gray = 8'h80;
        step();
        check("ld80_bin", 32'(bin_out), 32'hFF);
        ld = 1'b0;
        step();
        check("ldstep_bin",  32'(bin_out), 32'h00);
        check("ldstep_wrap", 32'(wrap),    32'h1);
        en = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gray_counter_p.md
GRAY_COUNTER_P -- requirements
Module: gray_counter_p

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits; legal range 2..32.
REQ-002 Parameter SAT_MODE, default 0; 0 = wrap at terminal count, 1 = saturate at terminal count.
REQ-003 Parameter RESET_VAL, default 0, binary count value loaded on reset; must be < 2**WIDTH.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  count enable; one step per cycle while high.
REQ-007 up_dn  input  1  direction; 1 = increment, 0 = decrement.
REQ-008 clr  input  1  synchronous clear to binary 0.
REQ-009 load  input  1  synchronous load strobe (present only with GRAY_CNT_LOAD_EN).
REQ-010 load_gray  input  WIDTH  Gray-coded load value (present only with GRAY_CNT_LOAD_EN).
REQ-011 gray_out  output  WIDTH  registered Gray code of current count.
REQ-012 bin_out  output  WIDTH  registered binary count.
REQ-013 tc  output  1  terminal count flag for current direction.
REQ-014 wrap  output  1  registered one-cycle pulse on wrap-around.

Function
REQ-015 Internal state: binary register cnt; bin_out = cnt; gray_out register holds cnt ^ (cnt >> 1) of the same value, updated on the same edge.
REQ-016 Per-edge priority: clr > load > en > hold.
REQ-017 clr=1: cnt <- 0, gray_out <- 0, wrap <- 0, regardless of en/load/up_dn.
REQ-018 load=1 (clr=0): cnt <- Gray-to-binary of load_gray (bit i = XOR of load_gray[WIDTH-1:i]); gray_out <- load_gray; wrap <- 0.
REQ-019 en=1 (clr=0, load=0): cnt <- cnt+1 if up_dn=1, cnt-1 if up_dn=0, modulo 2**WIDTH when SAT_MODE=0.
REQ-020 Latency: outputs reflect an accepted operation one clock edge after it is sampled; consecutive enabled cycles step once per cycle.
REQ-021 en=0 with clr=0, load=0: all state holds; wrap <- 0.
REQ-022 tc is combinational from registered state: tc = (up_dn & cnt==2**WIDTH-1) | (~up_dn & cnt==0).
REQ-023 SAT_MODE=0: enabled step while tc=1 wraps (max->0 up, 0->max down) and sets wrap=1 for exactly the following cycle.
REQ-024 SAT_MODE=1: enabled step while tc=1 leaves cnt unchanged; wrap never asserts.
REQ-025 Each non-saturated enabled step changes exactly one bit of gray_out.
REQ-026 Direction change takes effect on the same edge it is sampled; no dead cycle.

Reset
REQ-027 rst=1 asynchronously forces cnt=RESET_VAL, gray_out=RESET_VAL ^ (RESET_VAL>>1), wrap=0, independent of clk.
REQ-028 While rst=1 all inputs are ignored; first update occurs on the first rising edge after rst deasserts.
REQ-029 Reset asserted mid-count discards the in-flight step; no wrap pulse is generated.

Configuration
REQ-030 Macro GRAY_CNT_LOAD_EN defined: load and load_gray ports exist and REQ-018 applies.
REQ-031 GRAY_CNT_LOAD_EN undefined: load and load_gray ports are absent, no Gray-to-binary logic is built, and priority is clr > en > hold.

Verification (WIDTH=8, RESET_VAL=0 unless stated)
REQ-032 rst pulse mid-cycle with no clock edge -> bin_out=0x00, gray_out=0x00, wrap=0 immediately; with RESET_VAL=5 -> bin_out=0x05, gray_out=0x07.
REQ-033 SAT_MODE=0, up_dn=1, en=1 for 256 cycles from 0 -> gray_out steps 00,01,03,02,06..., exactly one bit changes per step, tc=1 at bin_out=0xFF, next edge bin_out=0x00 with wrap=1 for exactly one cycle.
REQ-034 SAT_MODE=1, up_dn=0 from 0x02, en=1 for 5 cycles -> bin_out 01,00,00,00,00; tc=1 at 0x00; wrap stays 0.
REQ-035 GRAY_CNT_LOAD_EN, load=1, load_gray=0xC0 -> next edge bin_out=0x80, gray_out=0xC0; load and clr together -> bin_out=0x00.
REQ-036 Counting up at 0x10, up_dn toggled to 0 with en=1 -> next edge bin_out=0x0F; en=0 for 3 cycles -> outputs hold at 0x0F/0x08.
REQ-037 rst asserted between edges while counting at 0x40 -> outputs return to RESET_VAL asynchronously; after release counting resumes from RESET_VAL with no wrap pulse.
